// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128 key expansion: one round key per keyValid/keyReady handshake.
// Optional build macro KEY_SCHED_TRACE_EN adds a simulation trace of handshakes and completion.
module aes_key_schedule_iter #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] cipherKey,
   input  logic         keyReady,
   output logic [127:0] roundKey,
   output logic [3:0]   roundIndex,
   output logic         keyValid,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {StIdle, StEmit, StFinish} state_e;

   localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

   // Forward AES S-box, row-major; entry 0x00 sits in the top byte.
   localparam logic [2047:0] SBox = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBox[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         handshake;

   assign handshake = valid_q && keyReady;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rcon_d  = rcon_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_d   = cipherKey;
               idx_d   = 4'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               rcon_d  = 8'h01;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (handshake) begin
               if (idx_q == LastIdx) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StFinish;
               end else begin
                  key_d  = next_key(key_q, rcon_q);
                  idx_d  = idx_q + 4'd1;
                  rcon_d = xtime(rcon_q);
               end
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         key_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rcon_q  <= 8'h01;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rcon_q  <= rcon_d;
      end
   end

   assign roundKey   = key_q;
   assign roundIndex = idx_q;
   assign keyValid   = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

`ifdef KEY_SCHED_TRACE_EN
   always @(posedge clock) begin
      if (reset_n) begin
         if (handshake) $display("%m round %0d key %h", idx_q, key_q);
         if (done_q) $display("%m key schedule complete");
      end
   end
`else
`endif

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Scoreboard bench for aes_key_schedule_iter: FIPS-197 vectors, stalls, ignored starts,
// mid-sequence reset and a two-round build.
module tb_aes_key_schedule_iter;

   typedef struct packed {
      logic [3:0]   idx;
      logic         chk;
      logic [127:0] key;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         start, keyReady;
   logic [127:0] cipherKey;
   logic [127:0] roundKey;
   logic [3:0]   roundIndex;
   logic         keyValid, busy, done;

   logic         start2, keyReady2;
   logic [127:0] roundKey2;
   logic [3:0]   roundIndex2;
   logic         keyValid2, busy2, done2;

   logic [127:0] vec_a [0:10];
   logic [127:0] zero_r1, zero_r10;
   exp_t         sb [$];
   int           checks = 0;
   int           errors = 0;

   always #5 clock = ~clock;

   aes_key_schedule_iter #(.NUM_ROUNDS(10)) u_dut (
      .clock(clock), .reset_n(reset_n), .start(start), .cipherKey(cipherKey),
      .keyReady(keyReady), .roundKey(roundKey), .roundIndex(roundIndex),
      .keyValid(keyValid), .busy(busy), .done(done)
   );

   aes_key_schedule_iter #(.NUM_ROUNDS(2)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .start(start2), .cipherKey(cipherKey),
      .keyReady(keyReady2), .roundKey(roundKey2), .roundIndex(roundIndex2),
      .keyValid(keyValid2), .busy(busy2), .done(done2)
   );

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic push_vec_a(input int last);
      for (int i = 0; i <= last; i++) sb.push_back('{idx: 4'(i), chk: 1'b1, key: vec_a[i]});
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; start2 = 1'b0; keyReady = 1'b0; keyReady2 = 1'b0;
      cipherKey = vec_a[0];
      repeat (2) cycle();
      checks++;
      if (roundKey !== '0 || roundIndex !== 4'd0 || keyValid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0)
         begin
            errors++;
            $display("FAIL reset: key %h idx %0d v%b b%b d%b, required all zero",
                     roundKey, roundIndex, keyValid, busy, done);
         end
      checks++;
      if (roundKey2 !== '0 || keyValid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
         errors++;
         $display("FAIL reset2: key %h v%b b%b d%b, required all zero",
                  roundKey2, keyValid2, busy2, done2);
      end
      reset_n = 1'b1;
      keyReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (keyValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: v%b b%b d%b, required 0 0 0", keyValid, busy, done);
         end
      end
   endtask

   task automatic test_sequence();
      int   cyc;
      exp_t e;
      sb.delete();
      push_vec_a(10);
      cipherKey = vec_a[0]; keyReady = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      cipherKey = '1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 40) begin
         if (keyValid && keyReady) begin
            e = sb.pop_front();
            checks++;
            if (roundIndex !== e.idx || roundKey !== e.key || busy !== 1'b1) begin
               errors++;
               $display("FAIL seq_round: idx %0d key %h busy %b, required idx %0d key %h busy 1",
                        roundIndex, roundKey, busy, e.idx, e.key);
            end
         end
         cycle();
         cyc++;
      end
      checks++;
      if (sb.size() != 0 || cyc != 11) begin
         errors++;
         $display("FAIL seq_latency: %0d cycles %0d left, required 11 cycles 0 left",
                  cyc, sb.size());
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || keyValid !== 1'b0 || roundIndex !== 4'd10) begin
         errors++;
         $display("FAIL seq_done: d%b b%b v%b idx %0d, required d1 b0 v0 idx 10",
                  done, busy, keyValid, roundIndex);
      end
      start = 1'b1; cipherKey = vec_a[0];
      cycle();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || keyValid !== 1'b0) begin
         errors++;
         $display("FAIL finish_start: d%b b%b v%b, required d0 b0 v0", done, busy, keyValid);
      end
      cycle();
   endtask

   task automatic test_stall();
      int   cyc;
      bit   stalled;
      exp_t e;
      sb.delete();
      push_vec_a(10);
      cipherKey = vec_a[0]; keyReady = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      cyc = 0; stalled = 1'b0;
      while (sb.size() > 0 && cyc < 40) begin
         if (keyValid && roundIndex == 4'd4 && !stalled) begin
            stalled = 1'b1;
            keyReady = 1'b0;
            for (int s = 0; s < 3; s++) begin
               cycle();
               cyc++;
               checks++;
               if (roundIndex !== 4'd4 || roundKey !== vec_a[4] || keyValid !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_hold: idx %0d key %h v%b, required idx 4 key %h v1",
                           roundIndex, roundKey, keyValid, vec_a[4]);
               end
            end
            keyReady = 1'b1;
         end
         if (keyValid && keyReady) begin
            e = sb.pop_front();
            checks++;
            if (roundIndex !== e.idx || roundKey !== e.key) begin
               errors++;
               $display("FAIL stall_round: idx %0d key %h, required idx %0d key %h",
                        roundIndex, roundKey, e.idx, e.key);
            end
         end
         cycle();
         cyc++;
      end
      checks++;
      if (sb.size() != 0 || cyc != 14 || done !== 1'b1) begin
         errors++;
         $display("FAIL stall_latency: %0d cycles done %b, required 14 cycles done 1", cyc, done);
      end
      repeat (2) cycle();
   endtask

   task automatic test_start_while_busy();
      int   cyc;
      bit   injected;
      exp_t e;
      sb.delete();
      push_vec_a(10);
      cipherKey = vec_a[0]; keyReady = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      cyc = 0; injected = 1'b0;
      while (sb.size() > 0 && cyc < 40) begin
         start = 1'b0;
         if (keyValid && roundIndex == 4'd6 && !injected) begin
            injected = 1'b1;
            start = 1'b1;
            cipherKey = '0;
         end
         if (keyValid && keyReady) begin
            e = sb.pop_front();
            checks++;
            if (roundIndex !== e.idx || roundKey !== e.key) begin
               errors++;
               $display("FAIL busy_start_round: idx %0d key %h, required idx %0d key %h",
                        roundIndex, roundKey, e.idx, e.key);
            end
         end
         cycle();
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (sb.size() != 0 || cyc != 11 || done !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_end: %0d cycles done %b, required 11 cycles done 1",
                  cyc, done);
      end
      repeat (2) cycle();
   endtask

   task automatic test_reset_mid_and_zero_key();
      int   cyc;
      exp_t e;
      sb.delete();
      push_vec_a(10);
      cipherKey = vec_a[0]; keyReady = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      cyc = 0;
      while (!(keyValid && roundIndex == 4'd5) && cyc < 40) begin
         if (keyValid && keyReady) begin
            e = sb.pop_front();
            checks++;
            if (roundIndex !== e.idx || roundKey !== e.key) begin
               errors++;
               $display("FAIL pre_reset_round: idx %0d key %h, required idx %0d key %h",
                        roundIndex, roundKey, e.idx, e.key);
            end
         end
         cycle();
         cyc++;
      end
      checks++;
      if (cyc != 5) begin
         errors++;
         $display("FAIL pre_reset_reach: %0d cycles to round 5, required 5", cyc);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (keyValid !== 1'b0 || busy !== 1'b0 || roundKey !== '0 || roundIndex !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset: v%b b%b key %h idx %0d, required v0 b0 key 0 idx 0",
                  keyValid, busy, roundKey, roundIndex);
      end
      cycle();
      reset_n = 1'b1;
      cycle();
      sb.delete();
      for (int i = 0; i <= 10; i++) begin
         sb.push_back('{idx: 4'(i), chk: (i == 0 || i == 1 || i == 10),
                        key: (i == 1) ? zero_r1 : (i == 10) ? zero_r10 : 128'h0});
      end
      cipherKey = '0; start = 1'b1;
      cycle();
      start = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 40) begin
         if (keyValid && keyReady) begin
            e = sb.pop_front();
            checks++;
            if (roundIndex !== e.idx || (e.chk && roundKey !== e.key)) begin
               errors++;
               $display("FAIL zero_round: idx %0d key %h, required idx %0d key %h",
                        roundIndex, roundKey, e.idx, e.key);
            end
         end
         cycle();
         cyc++;
      end
      checks++;
      if (sb.size() != 0 || cyc != 11 || done !== 1'b1) begin
         errors++;
         $display("FAIL zero_end: %0d cycles done %b, required 11 cycles done 1", cyc, done);
      end
      repeat (2) cycle();
   endtask

   task automatic test_two_rounds();
      int   cyc;
      exp_t e;
      sb.delete();
      push_vec_a(2);
      cipherKey = vec_a[0]; keyReady2 = 1'b1; start2 = 1'b1;
      cycle();
      start2 = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         if (keyValid2 && keyReady2) begin
            e = sb.pop_front();
            checks++;
            if (roundIndex2 !== e.idx || roundKey2 !== e.key) begin
               errors++;
               $display("FAIL two_round: idx %0d key %h, required idx %0d key %h",
                        roundIndex2, roundKey2, e.idx, e.key);
            end
         end
         cycle();
         cyc++;
      end
      checks++;
      if (sb.size() != 0 || cyc != 3) begin
         errors++;
         $display("FAIL two_latency: %0d cycles %0d left, required 3 cycles 0 left",
                  cyc, sb.size());
      end
      checks++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || keyValid2 !== 1'b0 || roundIndex2 !== 4'd2) begin
         errors++;
         $display("FAIL two_done: d%b b%b v%b idx %0d, required d1 b0 v0 idx 2",
                  done2, busy2, keyValid2, roundIndex2);
      end
      cycle();
      checks++;
      if (done2 !== 1'b0 || keyValid2 !== 1'b0) begin
         errors++;
         $display("FAIL two_after: d%b v%b, required d0 v0", done2, keyValid2);
      end
   endtask

   initial begin
      vec_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      vec_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      vec_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      vec_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      vec_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      vec_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      vec_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      vec_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      vec_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      vec_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
      vec_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      zero_r1   = 128'h62636363626363636263636362636363;
      zero_r10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

      test_reset();
      test_sequence();
      test_stall();
      test_start_while_busy();
      test_reset_mid_and_zero_key();
      test_two_rounds();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
